// File: rtl/rpn_lan_tx_reliable.sv
// rpn_lan_tx_reliable
//   Reliable LAN transmit stage for remote publish messages. Each message
//   from Control gets the next per-destination sequence number, read from
//   the sequence BRAM. It is sent to the KIP TX interface, and the stage
//   then waits for the matching LAN ACK. A timeout resends the same sequence
//   number. Once the retries are used up, the stage reports an error. Only
//   an ACKed sequence number is written back to the BRAM.
//
// Ports
//   i_clk, i_ap_rst_n          clock, async active-low reset
//   i_node_id                  own node ID (sender field)
//   i_KIP_port_number          src and dest UDP port
//   from_ctrl_*                single-beat message in (tdest = node, tuser = IP)
//   to_nb_KIP_*                packet out to Network Bridge
//   from_nb_ack_*              ACK stream in (always ready)
//   seq_BRAM_*                 per-node last-ACKed sequence number BRAM
//   o_tx_done / o_tx_error     one-cycle completion / failure pulses
//   o_tx_node_id               destination of last completed/failed message
module rpn_lan_tx_reliable #(
  parameter int AXIS_DATA_WIDTH           = 512,
  parameter int AXIS_KEEP_WIDTH           = 64,
  parameter int NODE_ID_WIDTH             = 8,
  parameter int LAN_SEQUENCE_NUMBER_WIDTH = 32,
  parameter int RPN_MSG_TYPE_WIDTH        = 8,
  parameter int PUB_LAN_DATA_WIDTH        = 256,
  parameter int BRAM_ADDR_WIDTH           = 32,
  parameter int KIP_TUSER_WIDTH           = 64,
  parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_LAN_PUB = 8'h10,
  parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_LAN_ACK = 8'h11,
  parameter int TIMEOUT_CYCLES            = 1000,
  parameter int MAX_RETRIES               = 3
) (
  input  logic                                 i_clk,
  input  logic                                 i_ap_rst_n,
  input  logic [NODE_ID_WIDTH-1:0]             i_node_id,
  input  logic [15:0]                          i_KIP_port_number,
  // Control -> TX
  input  logic                                 from_ctrl_tvalid,
  output logic                                 from_ctrl_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]           from_ctrl_tdata,
  input  logic [NODE_ID_WIDTH-1:0]             from_ctrl_tdest,
  input  logic [31:0]                          from_ctrl_tuser,
  // TX -> Network Bridge KIP
  output logic                                 to_nb_KIP_tvalid,
  input  logic                                 to_nb_KIP_tready,
  output logic [AXIS_DATA_WIDTH-1:0]           to_nb_KIP_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]           to_nb_KIP_tkeep,
  output logic [KIP_TUSER_WIDTH-1:0]           to_nb_KIP_tuser,
  output logic                                 to_nb_KIP_tlast,
  // ACKs from Network Bridge
  input  logic                                 from_nb_ack_tvalid,
  output logic                                 from_nb_ack_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]           from_nb_ack_tdata,
  // Sequence-number BRAM
  output logic                                 seq_BRAM_CLK,
  output logic                                 seq_BRAM_RST,
  output logic                                 seq_BRAM_EN,
  output logic [3:0]                           seq_BRAM_WEN,
  output logic [BRAM_ADDR_WIDTH-1:0]           seq_BRAM_ADDR,
  output logic [LAN_SEQUENCE_NUMBER_WIDTH-1:0] seq_BRAM_DIN,
  input  logic [LAN_SEQUENCE_NUMBER_WIDTH-1:0] seq_BRAM_DOUT,
  // Status
  output logic                                 o_tx_done,
  output logic                                 o_tx_error,
  output logic [NODE_ID_WIDTH-1:0]             o_tx_node_id
);

  localparam int SEQ_W = LAN_SEQUENCE_NUMBER_WIDTH;
  localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int RTY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [SEQ_W-1:0] SEQ_ONE  = 1;
  localparam logic [TMO_W-1:0] TMO_ONE  = 1;
  localparam logic [RTY_W-1:0] RTY_ONE  = 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  // Field offsets inside tdata
  localparam int NODE_LSB = 8;
  localparam int SEQ_LSB  = 16;
  localparam int PL_LSB   = 48;

  typedef enum logic [2:0] {
    S_IDLE, S_READ_SEQ, S_TRANSMIT, S_WAIT_ACK, S_COMMIT
  } state_t;

  // Message latched at accept; held for every (re)transmission
  typedef struct packed {
    logic [PUB_LAN_DATA_WIDTH-1:0] payload;
    logic [NODE_ID_WIDTH-1:0]      dest;
    logic [NODE_ID_WIDTH-1:0]      sender;
    logic [31:0]                   ip;
  } msg_t;

  state_t           state, state_nxt;
  msg_t             r_msg;
  logic [SEQ_W-1:0] r_seq;
  logic [TMO_W-1:0] r_tmo;
  logic [RTY_W-1:0] r_rty;

  logic accept, ack_match, tmo_hit, rty_left;

  assign accept    = (state == S_IDLE) && from_ctrl_tvalid;
  assign tmo_hit   = (r_tmo == TMO_LAST);
  assign rty_left  = (r_rty < RTY_MAX);
  // A stale ACK (e.g. the duplicate for a retransmit) can't match because
  // r_seq is only ever the number currently in flight.
  assign ack_match = from_nb_ack_tvalid
                  && (from_nb_ack_tdata[RPN_MSG_TYPE_WIDTH-1:0] == RPN_MSG_TYPE_LAN_ACK)
                  && (from_nb_ack_tdata[NODE_LSB +: NODE_ID_WIDTH] == r_msg.dest)
                  && (from_nb_ack_tdata[SEQ_LSB +: SEQ_W] == r_seq);

  assign from_nb_ack_tready = 1'b1;
  assign seq_BRAM_CLK       = i_clk;
  assign seq_BRAM_RST       = ~i_ap_rst_n;

  // ---------------- state / datapath registers ----------------
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      state        <= S_IDLE;
      r_msg        <= '0;
      r_seq        <= '0;
      r_tmo        <= '0;
      r_rty        <= '0;
      o_tx_node_id <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        r_msg.payload <= from_ctrl_tdata[PUB_LAN_DATA_WIDTH-1:0];
        r_msg.dest    <= from_ctrl_tdest;
        r_msg.sender  <= i_node_id;
        r_msg.ip      <= from_ctrl_tuser;
      end
      if (state == S_READ_SEQ) begin
        r_seq <= seq_BRAM_DOUT + SEQ_ONE;   // wraps all-ones to 0
        r_rty <= '0;
      end
      // Timeout only runs while waiting, so a stalled KIP never times out
      if (state == S_TRANSMIT && to_nb_KIP_tready) r_tmo <= '0;
      else if (state == S_WAIT_ACK)                r_tmo <= r_tmo + TMO_ONE;
      if (state == S_WAIT_ACK && !ack_match && tmo_hit && rty_left)
        r_rty <= r_rty + RTY_ONE;
      if (state == S_COMMIT || o_tx_error) o_tx_node_id <= r_msg.dest;
    end
  end

  // ---------------- next state / control outputs ----------------
  always_comb begin
    state_nxt        = state;
    from_ctrl_tready = 1'b0;
    seq_BRAM_EN      = 1'b0;
    seq_BRAM_WEN     = 4'h0;
    seq_BRAM_ADDR    = BRAM_ADDR_WIDTH'(r_msg.dest) << 2;
    seq_BRAM_DIN     = r_seq;
    o_tx_done        = 1'b0;
    o_tx_error       = 1'b0;
    case (state)
      S_IDLE: begin
        from_ctrl_tready = 1'b1;
        if (from_ctrl_tvalid) begin
          seq_BRAM_EN   = 1'b1;
          seq_BRAM_ADDR = BRAM_ADDR_WIDTH'(from_ctrl_tdest) << 2;
          state_nxt     = S_READ_SEQ;
        end
      end
      S_READ_SEQ: state_nxt = S_TRANSMIT;
      S_TRANSMIT: if (to_nb_KIP_tready) state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        // ACK beats timeout when both land in the same cycle
        if (ack_match) state_nxt = S_COMMIT;
        else if (tmo_hit) begin
          if (rty_left) state_nxt = S_TRANSMIT;
          else begin
            o_tx_error = 1'b1;
            state_nxt  = S_IDLE;
          end
        end
      end
      S_COMMIT: begin
        seq_BRAM_EN  = 1'b1;
        seq_BRAM_WEN = 4'hF;
        o_tx_done    = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- KIP packet (from registers only) ----------------
  assign to_nb_KIP_tvalid = (state == S_TRANSMIT);
  assign to_nb_KIP_tkeep  = '1;
  assign to_nb_KIP_tlast  = 1'b1;
  assign to_nb_KIP_tuser  = KIP_TUSER_WIDTH'({i_KIP_port_number, i_KIP_port_number, r_msg.ip});

  always_comb begin
    to_nb_KIP_tdata                                 = '0;
    to_nb_KIP_tdata[RPN_MSG_TYPE_WIDTH-1:0]         = RPN_MSG_TYPE_LAN_PUB;
    to_nb_KIP_tdata[NODE_LSB +: NODE_ID_WIDTH]      = r_msg.sender;
    to_nb_KIP_tdata[SEQ_LSB +: SEQ_W]               = r_seq;
    to_nb_KIP_tdata[PL_LSB +: PUB_LAN_DATA_WIDTH]   = r_msg.payload;
  end

endmodule

// File: tb/tb_rpn_lan_tx_reliable.sv
module tb_rpn_lan_tx_reliable;
  localparam int DW = 512, KW = 64, NW = 8, SW = 32, PW = 256, AW = 32, UW = 64;
  localparam int TMO = 16, RTY = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NW-1:0] node_id = 8'h2A;
  logic [15:0]   port    = 16'h1234;

  logic          c_tvalid = 1'b0, c_tready;
  logic [DW-1:0] c_tdata  = '0;
  logic [NW-1:0] c_tdest  = '0;
  logic [31:0]   c_tuser  = '0;
  logic          k_tvalid, k_tready = 1'b1, k_tlast;
  logic [DW-1:0] k_tdata;
  logic [KW-1:0] k_tkeep;
  logic [UW-1:0] k_tuser;
  logic          a_tvalid = 1'b0, a_tready;
  logic [DW-1:0] a_tdata  = '0;
  logic          b_clk, b_rst, b_en;
  logic [3:0]    b_wen;
  logic [AW-1:0] b_addr;
  logic [SW-1:0] b_din, b_dout;
  logic          tx_done, tx_error;
  logic [NW-1:0] tx_node;

  rpn_lan_tx_reliable #(.TIMEOUT_CYCLES(TMO), .MAX_RETRIES(RTY)) dut (
    .i_clk(clk), .i_ap_rst_n(rst_n), .i_node_id(node_id), .i_KIP_port_number(port),
    .from_ctrl_tvalid(c_tvalid), .from_ctrl_tready(c_tready), .from_ctrl_tdata(c_tdata),
    .from_ctrl_tdest(c_tdest), .from_ctrl_tuser(c_tuser),
    .to_nb_KIP_tvalid(k_tvalid), .to_nb_KIP_tready(k_tready), .to_nb_KIP_tdata(k_tdata),
    .to_nb_KIP_tkeep(k_tkeep), .to_nb_KIP_tuser(k_tuser), .to_nb_KIP_tlast(k_tlast),
    .from_nb_ack_tvalid(a_tvalid), .from_nb_ack_tready(a_tready), .from_nb_ack_tdata(a_tdata),
    .seq_BRAM_CLK(b_clk), .seq_BRAM_RST(b_rst), .seq_BRAM_EN(b_en), .seq_BRAM_WEN(b_wen),
    .seq_BRAM_ADDR(b_addr), .seq_BRAM_DIN(b_din), .seq_BRAM_DOUT(b_dout),
    .o_tx_done(tx_done), .o_tx_error(tx_error), .o_tx_node_id(tx_node)
  );

  // BRAM model: 1-cycle read latency, word per node
  logic [SW-1:0] mem [256];
  always @(posedge clk) begin
    if (b_en) begin
      if (b_wen == 4'hF) mem[b_addr[9:2]] = b_din;
      b_dout <= mem[b_addr[9:2]];
    end
  end

  int total = 0, bad = 0;
  int pkt_cnt = 0, done_cnt = 0, err_cnt = 0;
  int cyc = 0, last_hs_cyc = 0, err_cyc = 0;

  typedef struct { logic [DW-1:0] data; logic [UW-1:0] user; } pkt_t;
  pkt_t exp_q[$];
  pkt_t e;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pub_pkt(input logic [SW-1:0] seq, input logic [PW-1:0] pl);
    logic [DW-1:0] d;
    d = '0;
    d[7:0]    = 8'h10;
    d[15:8]   = node_id;
    d[47:16]  = seq;
    d[303:48] = pl;
    return d;
  endfunction

  function automatic logic [DW-1:0] ack_dat(input logic [7:0] typ, input logic [NW-1:0] node,
                                           input logic [SW-1:0] seq);
    logic [DW-1:0] d;
    d = '0;
    d[7:0] = typ; d[15:8] = node; d[47:16] = seq;
    return d;
  endfunction

  // Scoreboard: pop and compare on every KIP handshake
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_n && k_tvalid && k_tready) begin
      pkt_cnt++;
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pkt: got %0h want none", k_tdata[63:0]);
      end else begin
        e = exp_q.pop_front();
        check("pkt_tdata", k_tdata, e.data);
        check("pkt_tuser", DW'(k_tuser), DW'(e.user));
        check("pkt_keep_last", DW'({k_tkeep, k_tlast}), DW'({{KW{1'b1}}, 1'b1}));
      end
    end
    if (rst_n && tx_done) done_cnt++;
    if (rst_n && tx_error) begin err_cnt++; err_cyc = cyc; end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic [SW-1:0] seq, input logic [PW-1:0] pl, input logic [31:0] ip);
    pkt_t p;
    p.data = pub_pkt(seq, pl);
    p.user = {port, port, ip};
    exp_q.push_back(p);
  endtask

  task automatic send(input logic [NW-1:0] node, input logic [31:0] ip, input logic [PW-1:0] pl,
                      input logic [SW-1:0] seq);
    check("ctrl_ready_before_send", DW'(c_tready), DW'(1'b1));
    push_exp(seq, pl, ip);
    c_tvalid = 1'b1; c_tdest = node; c_tuser = ip; c_tdata = DW'(pl);
    tick;
    c_tvalid = 1'b0; c_tdata = '0;
  endtask

  task automatic send_ack(input logic [7:0] typ, input logic [NW-1:0] node, input logic [SW-1:0] seq);
    a_tvalid = 1'b1; a_tdata = ack_dat(typ, node, seq);
    tick;
    a_tvalid = 1'b0; a_tdata = '0;
  endtask

  task automatic wait_pkt(input int target, input int budget);
    int n = 0;
    while (pkt_cnt < target && n < budget) begin tick; n++; end
    check("wait_pkt", DW'(pkt_cnt >= target), DW'(1'b1));
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin tick; n++; end
    check("wait_done", DW'(done_cnt >= target), DW'(1'b1));
  endtask

  task automatic wait_err(input int target, input int budget);
    int n = 0;
    while (err_cnt < target && n < budget) begin tick; n++; end
    check("wait_err", DW'(err_cnt >= target), DW'(1'b1));
  endtask

  typedef struct {
    logic [NW-1:0] node; logic [31:0] ip; logic [PW-1:0] pl;
    logic [SW-1:0] init; logic [SW-1:0] seq;
  } vec_t;
  vec_t vt[4];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d0;
    logic [UW-1:0] u0;
    int b, dn, er, dt;

    vt[0] = '{8'd5,   32'h0A000005, 256'hABCD,       32'h0,        32'h1};
    vt[1] = '{8'd3,   32'h0A000003, 256'h12345678,   32'hFFFFFFFF, 32'h0};
    vt[2] = '{8'd9,   32'hC0A80109, {8{32'hDEADBEEF}}, 32'd41,     32'd42};
    vt[3] = '{8'd255, 32'hFFFFFFFF, {PW{1'b1}},      32'h7FFFFFFF, 32'h80000000};
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_kip_tvalid", DW'(k_tvalid), '0);
    check("rst_ctrl_tready", DW'(c_tready), DW'(1'b1));
    check("rst_ack_tready", DW'(a_tready), DW'(1'b1));
    check("rst_bram_en_wen", DW'({b_en, b_wen}), '0);
    check("rst_done_err_node", DW'({tx_done, tx_error, tx_node}), '0);
    check("rst_bram_rst", DW'(b_rst), DW'(1'b1));
    rst_n = 1'b1;
    tick;

    // Table-driven normal transactions
    for (int i = 0; i < 4; i++) begin
      mem[vt[i].node] = vt[i].init;
      dn = done_cnt;
      send(vt[i].node, vt[i].ip, vt[i].pl, vt[i].seq);
      wait_pkt(pkt_cnt + 1, 20);
      tick;
      send_ack(8'h11, vt[i].node, vt[i].seq);
      wait_done(dn + 1, 10);
      tick;
      check("vec_bram", DW'(mem[vt[i].node]), DW'(vt[i].seq));
      check("vec_node_id", DW'(tx_node), DW'(vt[i].node));
    end

    // No ACK: 4 identical packets then error, BRAM untouched
    mem[7] = 32'd100;
    b = pkt_cnt; dn = done_cnt; er = err_cnt;
    send(8'd7, 32'h0A000007, 256'h77, 32'd101);
    for (int i = 0; i < RTY; i++) push_exp(32'd101, 256'h77, 32'h0A000007);
    wait_pkt(b + 1, 20);
    dt = last_hs_cyc;
    wait_err(er + 1, (RTY + 1) * (TMO + 1) + 20);
    check("retry_pkt_count", DW'(pkt_cnt - b), DW'(RTY + 1));
    dt = err_cyc - dt;
    if (!(dt >= 66 && dt <= 68)) begin
      total++; bad++;
      $display("FAIL retry_err_timing: got %0d want 67", dt);
    end else total++;
    repeat (30) tick;
    check("retry_no_more_pkts", DW'(pkt_cnt - b), DW'(RTY + 1));
    check("retry_err_once", DW'(err_cnt - er), DW'(1));
    check("retry_no_done", DW'(done_cnt), DW'(dn));
    check("retry_bram_kept", DW'(mem[7]), DW'(32'd100));
    check("retry_node_id", DW'(tx_node), DW'(8'd7));

    // Non-matching ACKs ignored, matching commits
    mem[2] = 32'd6;
    dn = done_cnt;
    send(8'd2, 32'h0A000002, 256'h22, 32'd7);
    wait_pkt(pkt_cnt + 1, 20);
    send_ack(8'h11, 8'd2, 32'd6);
    send_ack(8'h11, 8'd4, 32'd7);
    send_ack(8'h10, 8'd2, 32'd7);
    repeat (2) tick;
    check("nomatch_no_done", DW'(done_cnt), DW'(dn));
    send_ack(8'h11, 8'd2, 32'd7);
    wait_done(dn + 1, 5);
    tick;
    check("match_bram", DW'(mem[2]), DW'(32'd7));

    // KIP stall: packet held stable, no timeout counting; ACK at expiry wins
    mem[8] = '0;
    k_tready = 1'b0;
    b = pkt_cnt; dn = done_cnt; er = err_cnt;
    send(8'd8, 32'h0A000008, 256'h88, 32'd1);
    repeat (2) tick;
    d0 = k_tdata; u0 = k_tuser;
    repeat (10) tick;
    check("stall_tvalid", DW'(k_tvalid), DW'(1'b1));
    check("stall_tdata", k_tdata, d0);
    check("stall_tuser", DW'(k_tuser), DW'(u0));
    k_tready = 1'b1;
    tick;
    repeat (TMO - 1) tick;
    send_ack(8'h11, 8'd8, 32'd1);
    wait_done(dn + 1, 5);
    repeat (20) tick;
    check("expiry_ack_no_retx", DW'(pkt_cnt - b), DW'(1));
    check("expiry_ack_no_err", DW'(err_cnt), DW'(er));
    check("expiry_bram", DW'(mem[8]), DW'(32'd1));

    // Reset during WAIT_ACK
    mem[6] = 32'd20;
    send(8'd6, 32'h0A000006, 256'h66, 32'd21);
    wait_pkt(pkt_cnt + 1, 20);
    repeat (3) tick;
    rst_n = 1'b0;
    #1;
    check("midrst_kip_tvalid", DW'(k_tvalid), '0);
    check("midrst_ctrl_tready", DW'(c_tready), DW'(1'b1));
    check("midrst_bram_en_wen", DW'({b_en, b_wen}), '0);
    check("midrst_done_err_node", DW'({tx_done, tx_error, tx_node}), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    check("midrst_bram_kept", DW'(mem[6]), DW'(32'd20));
    dn = done_cnt;
    send(8'd6, 32'h0A000006, 256'h66, 32'd21);
    wait_pkt(pkt_cnt + 1, 20);
    tick;
    send_ack(8'h11, 8'd6, 32'd21);
    wait_done(dn + 1, 10);
    tick;
    check("postrst_bram", DW'(mem[6]), DW'(32'd21));
    check("exp_q_drained", DW'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rpn_lan_tx_reliable.md
# rpn_lan_tx_reliable

Reliable LAN transmit stage for remote publish messages. It sits between the Control module and the Network Bridge KnownIP (KIP) TX interface, directly upstream of the remote node's LAN receive stage. For each message it assigns the next per-destination sequence number from a sequence-number BRAM, transmits the message, and waits for the matching LAN ACK. On timeout it retransmits the same sequence number, and it reports failure after a bounded number of retries.

## Interface
Parameters:
- AXIS_DATA_WIDTH, 512: tdata width on all streams.
- AXIS_KEEP_WIDTH, 64: tkeep width.
- NODE_ID_WIDTH, 8: node ID width; also the BRAM entry-index width.
- LAN_SEQUENCE_NUMBER_WIDTH, 32: sequence number width.
- RPN_MSG_TYPE_WIDTH, 8: message type field, tdata[7:0].
- PUB_LAN_DATA_WIDTH, 256: payload width.
- BRAM_ADDR_WIDTH, 32: byte address width.
- KIP_TUSER_WIDTH, 64: tuser layout is IP [31:0], src port [47:32], dest port [63:48].
- RPN_MSG_TYPE_LAN_PUB, 8'h10: outgoing message type.
- RPN_MSG_TYPE_LAN_ACK, 8'h11: ACK message type.
- TIMEOUT_CYCLES, 1000: cycles spent in WAIT_ACK before a retransmit.
- MAX_RETRIES, 3: retransmits allowed after the first transmission.

Ports:
- i_clk, in, 1: clock.
- i_ap_rst_n, in, 1: asynchronous, active-low reset.
- i_node_id, in, NODE_ID_WIDTH: own node ID, placed in the sender field.
- i_KIP_port_number, in, 16: used as both the src port and the dest port.
- from_ctrl_tvalid / from_ctrl_tready, in / out, 1: single-beat message handshake.
- from_ctrl_tdata, in, AXIS_DATA_WIDTH: payload in [PUB_LAN_DATA_WIDTH-1:0].
- from_ctrl_tdest, in, NODE_ID_WIDTH: destination node ID.
- from_ctrl_tuser, in, 32: destination IP.
- to_nb_KIP_tvalid / to_nb_KIP_tready, out / in, 1: packet handshake.
- to_nb_KIP_tdata, out, AXIS_DATA_WIDTH: type [7:0], sender ID [15:8], sequence [47:16], payload [303:48], zeros above bit 303.
- to_nb_KIP_tkeep, out, AXIS_KEEP_WIDTH: all ones.
- to_nb_KIP_tuser, out, KIP_TUSER_WIDTH: destination IP plus ports.
- to_nb_KIP_tlast, out, 1: constant 1.
- from_nb_ack_tvalid / from_nb_ack_tready, in / out, 1: ACK stream. tready is constant 1.
- from_nb_ack_tdata, in, AXIS_DATA_WIDTH: type [7:0], ACKing node [15:8], sequence [47:16].
- seq_BRAM_CLK / RST / EN, out, 1: CLK = i_clk, RST = ~i_ap_rst_n.
- seq_BRAM_WEN, out, 4: write enable.
- seq_BRAM_ADDR, out, BRAM_ADDR_WIDTH: byte address = node ID << 2.
- seq_BRAM_DIN / DOUT, out / in, LAN_SEQUENCE_NUMBER_WIDTH: BRAM write and read data.
- o_tx_done, out, 1: one-cycle pulse on a successful ACK.
- o_tx_error, out, 1: one-cycle pulse when retries are exhausted.
- o_tx_node_id, out, NODE_ID_WIDTH: destination of the last completed or failed message.

## Operation
Each BRAM entry holds the last sequence number successfully ACKed by that destination. All entries reset externally to 0, so the first message to any node carries sequence 1.

States and transitions:
- IDLE: from_ctrl_tready=1. On accept, latch payload, tdest, IP; assert BRAM EN with ADDR=tdest<<2; go to READ_SEQ.
- READ_SEQ: DOUT is valid this cycle. Latch r_seq = DOUT+1, computed modulo 2^LAN_SEQUENCE_NUMBER_WIDTH (so all-ones wraps to 0). Clear the retry counter. Go to TRANSMIT.
- TRANSMIT: to_nb_KIP_tvalid=1 with the registered packet. On tready, clear the timeout counter and go to WAIT_ACK.
- WAIT_ACK: the timeout counter increments every cycle. An ACK matches when tvalid, type == LAN_ACK, node [15:8] == latched tdest, and sequence == r_seq. Transitions, in priority order:
  - Match: go to COMMIT.
  - Counter reaches TIMEOUT_CYCLES-1 and retries < MAX_RETRIES: increment retries, go to TRANSMIT. The retransmit reuses r_seq unchanged.
  - Counter reaches TIMEOUT_CYCLES-1 and retries == MAX_RETRIES: pulse o_tx_error, go to IDLE. The BRAM is not written.
- COMMIT: EN=1, WEN=4'hF, ADDR=tdest<<2, DIN=r_seq. Pulse o_tx_done. Go to IDLE.

Other rules:
- ACKs received in any state other than WAIT_ACK, and non-matching ACKs, are consumed and discarded.
- An ACK with a stale sequence, such as the duplicate ACK the receiver sends for a retransmit, never matches.

## Timing
- Reset: state IDLE.
- Reset values of outputs: all tvalid 0, from_ctrl_tready 1, from_nb_ack_tready 1, BRAM EN 0, BRAM WEN 0, o_tx_done 0, o_tx_error 0, o_tx_node_id 0.
- All internal counters and registers reset to 0.
- Reset mid-operation abandons the message and leaves the BRAM unwritten.
- Latency from from_ctrl accept to to_nb_KIP_tvalid is 2 cycles: READ_SEQ, then TRANSMIT. BRAM read latency is 1 cycle.
- A matching ACK in cycle N gives COMMIT (BRAM write and o_tx_done) in cycle N+1; from_ctrl_tready returns in N+2.
- to_nb_KIP outputs are registered and held stable while tvalid=1 and tready=0.
- A match and a timeout in the same cycle: the ACK wins.
- Worst-case time to o_tx_error: (MAX_RETRIES+1)·TIMEOUT_CYCLES cycles, plus transmit stalls.

## Test plan
- BRAM[5]=0. Send payload 0xABCD to node 5, IP 0x0A000005. Expect a KIP packet with type 0x10, sender=i_node_id, seq=1, tuser IP 0x0A000005. ACK(5,1) → BRAM[5]=1, o_tx_done.
- BRAM[3]=32'hFFFFFFFF. Send to node 3 → seq=0 in the packet. ACK(3,0) → BRAM[3]=0.
- No ACK, TIMEOUT_CYCLES=16, MAX_RETRIES=3 → 4 identical packets with the same sequence. o_tx_error pulses at the fourth timeout. BRAM unchanged.
- In WAIT_ACK for seq 7 to node 2, feed ACK(2,6) and then ACK(4,7) → both ignored. ACK(2,7) → commit.
- Hold to_nb_KIP_tready=0 for 10 cycles → tdata and tuser stable and no timeout counting. Then an ACK in the same cycle the timeout expires → o_tx_done, no retransmit.
- Assert reset during WAIT_ACK → all outputs at reset values immediately. The next message to the same node reuses the same sequence.
